if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 stall  input  1  hazard stall from the decode stage; holds PC and the IF/ID register.
REQ-004 flush  input  1  clears the IF/ID register to a bubble.
REQ-005 redirect_valid  input  1  branch/jump target valid, from the decode stage.
REQ-006 redirect_pc  input  32  branch/jump target address.
REQ-007 im_addr  output  32  fetch address to instruction memory; equals the PC register.
REQ-008 im_instr  input  32  instruction word from instruction memory, combinational from im_addr.
REQ-009 d_instr  output  32  IF/ID instruction.
REQ-010 d_pc  output  32  IF/ID PC.
REQ-011 d_pc8  output  32  d_pc + 8; the link address.
REQ-012 d_valid  output  1  IF/ID holds a real fetched instruction.
REQ-013 d_exc  output  1  fetch-address fault for the IF/ID instruction; see Configuration.
REQ-014 fetch_cnt  output  32  count of instructions accepted into IF/ID.

Function
REQ-015 PC SHALL be a 32-bit register; im_addr SHALL equal PC combinationally.
REQ-016 Without stall, PC SHALL take the following next values:
- redirect_valid=1: redirect_pc.
- otherwise: PC+4, with 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
REQ-017 Branches SHALL be delayed:
- A redirect SHALL NOT squash the instruction currently in fetch; that instruction is the delay slot and enters IF/ID normally.
REQ-018 With stall=1, PC and the IF/ID register SHALL hold; redirect_valid SHALL be ignored that cycle.
- The decode stage SHALL hold redirect_valid and redirect_pc until stall deasserts.
REQ-019 With stall=0 and flush=0, IF/ID SHALL load on each edge:
- d_instr <= im_instr
- d_pc <= PC
- d_valid <= 1
REQ-020 With flush=1, IF/ID SHALL load d_instr=0, d_pc=PC, d_valid=0 and d_exc=0, regardless of stall.
- PC SHALL follow REQ-016/REQ-018 independently of flush.
REQ-021 d_pc8 SHALL be combinational d_pc + 8, modulo 2^32.
REQ-022 fetch_cnt SHALL increment by 1, wrapping at 2^32, on each edge where IF/ID loads with d_valid=1.
- It SHALL hold on stall or flush.
REQ-023 Fetch latency SHALL be one cycle: the instruction at PC appears on d_instr after the next edge.

Reset
REQ-024 On reset=1 at an edge, the block SHALL load:
- PC = 0x0000_3000
- d_instr = 0, d_pc = 0x0000_3000, d_valid = 0, d_exc = 0
- fetch_cnt = 0
REQ-025 Reset SHALL take priority over stall, flush and redirect_valid, including a reset asserted mid-stall.
REQ-026 The first fetch after reset deassert SHALL be from 0x0000_3000.

Configuration
REQ-027 Macro IF_ADDR_CHECK_EN, when defined, SHALL enable fetch-address checking.
- A fault is PC[1:0] != 0, or PC outside 0x0000_3000..0x0000_6FFF inclusive.
- On a faulting load, IF/ID SHALL capture d_instr=0 (nop) and d_exc=1; d_pc SHALL still be the faulting PC and d_valid SHALL be 1.
REQ-028 Without IF_ADDR_CHECK_EN, port d_exc SHALL exist and SHALL be constant 0.
- im_instr SHALL pass unchecked.

Verification
REQ-029 Reset, then 3 unstalled cycles:
- im_addr sequence 0x3000, 0x3004, 0x3008
- d_pc 0x3000, then 0x3004
- fetch_cnt = 3
REQ-030 Redirect, with PC=0x3008 and redirect_valid=1, redirect_pc=0x3100:
- Next edge: PC=0x3100 and d_pc=0x3008 (delay slot kept).
- Following edge: d_pc=0x3100.
REQ-031 Stall, with stall=1 for 2 cycles at PC=0x3010 and redirect_valid=1, redirect_pc=0x3200 held:
- PC and d_* hold and fetch_cnt holds.
- After release: PC=0x3200.
REQ-032 flush=1 together with stall=1 at PC=0x3020:
- d_valid=0, d_instr=0
- PC stays 0x3020
REQ-033 IF_ADDR_CHECK_EN defined, redirect_pc=0x3002:
- Next fetch loads d_exc=1, d_instr=0, d_pc=0x3002.
- Without the macro: d_exc=0 and d_instr = im_instr.
REQ-034 reset=1 asserted mid-stall with PC=0x3040:
- Next edge: PC=0x3000, fetch_cnt=0, d_valid=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch: PC register plus IF/ID pipeline register with delayed branches.
// Define IF_ADDR_CHECK_EN to fault fetches that are misaligned or outside 0x3000..0x6FFF.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic        d_exc,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault;

`ifdef IF_ADDR_CHECK_EN
  assign fault = (pc_q[1:0] != 2'b00)
              || (pc_q < 32'h0000_3000)
              || (pc_q > 32'h0000_6FFF);
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      pc_d = redirect_valid ? redirect_pc : pc_q + 32'd4;
    end
    // Flush wins over stall for IF/ID; the delay slot is never squashed by a redirect
    if (flush) begin
      instr_d = '0;
      dpc_d   = pc_q;
      valid_d = 1'b0;
      exc_d   = 1'b0;
    end else if (!stall) begin
      instr_d = fault ? 32'h0 : im_instr;
      dpc_d   = pc_q;
      valid_d = 1'b1;
      exc_d   = fault;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      dpc_q   <= RESET_PC;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign im_addr   = pc_q;
  assign d_instr   = instr_q;
  assign d_pc      = dpc_q;
  assign d_pc8     = dpc_q + 32'd8;
  assign d_valid   = valid_q;
  assign d_exc     = exc_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns address XOR a key.
// Define IF_ADDR_CHECK_EN here too when building the checked variant.
module tb_if_stage;

  localparam logic [31:0] K = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr, im_instr;
  logic [31:0] d_instr, d_pc, d_pc8, fetch_cnt;
  logic        d_valid, d_exc;

  int checks = 0;
  int passed = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_instr(im_instr),
    .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8),
    .d_valid(d_valid), .d_exc(d_exc), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  assign im_instr = im_addr ^ K;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step();
    chk("rst_pc", im_addr, 32'h3000);
    chk("rst_dpc", d_pc, 32'h3000);
    chk("rst_dinstr", d_instr, 32'h0);
    chk("rst_dvalid", {31'b0, d_valid}, 32'h0);
    chk("rst_dexc", {31'b0, d_exc}, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_pc8", d_pc8, 32'h3008);

    reset = 1'b0;
    chk("first_fetch", im_addr, 32'h3000);
    step();
    chk("seq1_pc", im_addr, 32'h3004);
    chk("seq1_dpc", d_pc, 32'h3000);
    chk("seq1_instr", d_instr, 32'h3000 ^ K);
    chk("seq1_valid", {31'b0, d_valid}, 32'h1);
    chk("seq1_cnt", fetch_cnt, 32'd1);
    step();
    chk("seq2_pc", im_addr, 32'h3008);
    chk("seq2_dpc", d_pc, 32'h3004);
    chk("seq2_pc8", d_pc8, 32'h300C);

    // delayed branch
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    step();
    chk("br_pc", im_addr, 32'h3100);
    chk("br_slot", d_pc, 32'h3008);
    chk("br_cnt", fetch_cnt, 32'd3);
    redirect_valid = 1'b0;
    step();
    chk("br_tgt_dpc", d_pc, 32'h3100);
    chk("br_tgt_pc", im_addr, 32'h3104);

    redirect_valid = 1'b1; redirect_pc = 32'h3010;
    step();
    chk("to3010", im_addr, 32'h3010);
    chk("to3010_cnt", fetch_cnt, 32'd5);

    // stall with held redirect
    stall = 1'b1; redirect_pc = 32'h3200;
    step();
    chk("st1_pc", im_addr, 32'h3010);
    chk("st1_dpc", d_pc, 32'h3104);
    step();
    chk("st2_pc", im_addr, 32'h3010);
    chk("st2_dpc", d_pc, 32'h3104);
    chk("st2_instr", d_instr, 32'h3104 ^ K);
    chk("st2_cnt", fetch_cnt, 32'd5);
    stall = 1'b0;
    step();
    chk("st_rel_pc", im_addr, 32'h3200);
    chk("st_rel_dpc", d_pc, 32'h3010);
    chk("st_rel_cnt", fetch_cnt, 32'd6);

    redirect_pc = 32'h3020;
    step();
    redirect_valid = 1'b0;
    chk("to3020", im_addr, 32'h3020);

    // flush together with stall
    flush = 1'b1; stall = 1'b1;
    step();
    chk("fs_pc", im_addr, 32'h3020);
    chk("fs_valid", {31'b0, d_valid}, 32'h0);
    chk("fs_instr", d_instr, 32'h0);
    chk("fs_dpc", d_pc, 32'h3020);
    chk("fs_cnt", fetch_cnt, 32'd7);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("fs_after_pc", im_addr, 32'h3024);
    chk("fs_after_valid", {31'b0, d_valid}, 32'h1);
    chk("fs_after_cnt", fetch_cnt, 32'd8);
    flush = 1'b1;
    step();
    chk("fl_pc", im_addr, 32'h3028);
    chk("fl_valid", {31'b0, d_valid}, 32'h0);
    chk("fl_dpc", d_pc, 32'h3024);
    chk("fl_cnt", fetch_cnt, 32'd8);
    flush = 1'b0;

    // misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h3002;
    step();
    chk("mis_pc", im_addr, 32'h3002);
    redirect_valid = 1'b0;
    step();
    chk("mis_dpc", d_pc, 32'h3002);
    chk("mis_valid", {31'b0, d_valid}, 32'h1);
`ifdef IF_ADDR_CHECK_EN
    chk("mis_exc", {31'b0, d_exc}, 32'h1);
    chk("mis_instr", d_instr, 32'h0);
`else
    chk("mis_exc", {31'b0, d_exc}, 32'h0);
    chk("mis_instr", d_instr, 32'h3002 ^ K);
`endif
    chk("mis_cnt", fetch_cnt, 32'd10);

    // top of window, then wrap at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'h6FFC;
    step();
    redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("hi_pc", im_addr, 32'hFFFF_FFFC);
    chk("hi_dpc", d_pc, 32'h6FFC);
    chk("hi_exc", {31'b0, d_exc}, 32'h0);
    chk("hi_instr", d_instr, 32'h6FFC ^ K);
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc", im_addr, 32'h0);
    chk("wrap_dpc", d_pc, 32'hFFFF_FFFC);
    chk("wrap_pc8", d_pc8, 32'h4);
`ifdef IF_ADDR_CHECK_EN
    chk("wrap_exc", {31'b0, d_exc}, 32'h1);
`else
    chk("wrap_exc", {31'b0, d_exc}, 32'h0);
`endif
    chk("wrap_cnt", fetch_cnt, 32'd13);

    // reset in the middle of a stall
    redirect_valid = 1'b1; redirect_pc = 32'h3040;
    step();
    redirect_valid = 1'b0;
    chk("to3040", im_addr, 32'h3040);
    stall = 1'b1;
    step();
    chk("ms_hold", im_addr, 32'h3040);
    reset = 1'b1;
    step();
    chk("ms_rst_pc", im_addr, 32'h3000);
    chk("ms_rst_cnt", fetch_cnt, 32'h0);
    chk("ms_rst_valid", {31'b0, d_valid}, 32'h0);
    chk("ms_rst_dpc", d_pc, 32'h3000);
    reset = 1'b0; stall = 1'b0;
    step();
    chk("post_pc", im_addr, 32'h3004);
    chk("post_dpc", d_pc, 32'h3000);
    chk("post_cnt", fetch_cnt, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
